nios2_debug_ocimem_arbiter: RTL
===============================

# nios2_debug_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (OCI RAM) between the JTAG debug path and the CPU's Avalon-MM debug memory slave. The JTAG side arrives as single-cycle `take_action_*` strobes plus the 38-bit `jdo` word, already in the system clock domain. The CPU side is a standard waitrequest-based Avalon slave. The block owns the RAM port, buffers one JTAG command, alternates grants fairly, and returns read data to `MonDReg`.

## Interface
- `ADDR_W`, default 8: OCI RAM word-address width (1..32).
- `DATA_W`: fixed at 32, the RAM word width.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `jdo` input 38: JTAG data word.
- `take_action_ocimem_a` input 1: load the JTAG address from `jdo[ADDR_W-1:0]`.
- `take_action_ocimem_b` input 1: JTAG write of `jdo[31:0]` at the JTAG address.
- `take_no_action_ocimem_a` input 1: JTAG read at the JTAG address.
- `avs_address` input ADDR_W: CPU word address.
- `avs_read` input 1: CPU read request.
- `avs_write` input 1: CPU write request.
- `avs_writedata` input 32: CPU write data.
- `avs_byteenable` input 4: CPU byte enables.
- `avs_readdata` output 32: CPU read data.
- `avs_waitrequest` output 1: CPU stall.
- `ram_addr` output ADDR_W: RAM address.
- `ram_wdata` output 32: RAM write data.
- `ram_be` output 4: RAM byte enables.
- `ram_we` output 1: RAM write enable.
- `ram_rdata` input 32: RAM read data, valid one clock after the address.
- `MonDReg` output 32: last JTAG read data.
- `jtag_busy` output 1: a JTAG command is pending or in flight.
- `jtag_overrun` output 1: sticky flag; a JTAG command was dropped.

## Operation
- **JTAG command buffer.** One entry: `jpend`, `jwr`, `jdata`.
  - `take_action_ocimem_b` sets `jpend=1`, `jwr=1`, `jdata=jdo[31:0]`.
  - `take_no_action_ocimem_a` sets `jpend=1`, `jwr=0`.
  - Any command strobe while `jpend` is set, or while a JTAG operation is in flight, is dropped and sets `jtag_overrun`.
- **JTAG address load.**
  - `take_action_ocimem_a` loads `jaddr=jdo[ADDR_W-1:0]` and clears `jtag_overrun`.
  - If it coincides with an in-flight JTAG operation, the load still applies and the in-flight operation's auto-increment is discarded.
  - Address strobes are never dropped.
- **CPU request.** `creq = avs_read | avs_write`. `avs_write` wins if both are asserted. The request is sampled only in IDLE.
- **Arbitration.**
  - Performed in IDLE only.
  - If one side requests, it is granted.
  - If both request, the side not served last is granted.
  - `last` resets to "CPU served", so JTAG wins the first tie.
- **FSM states.**
  - IDLE: on a grant, register `ram_addr`, `ram_wdata` and `ram_be`.
    - Write grant: set `ram_we<=1`, go to WR.
    - Read grant: go to RD1.
    - Otherwise stay in IDLE.
    - A JTAG operation uses `ram_be=4'hF` and `ram_addr=jaddr`.
  - WR: `ram_we=1` for exactly this cycle.
    - CPU owner: `avs_waitrequest=0`.
    - JTAG owner: `jaddr<=jaddr+1`, clear `jpend`.
    - Next state IDLE.
  - RD1: RAM samples the address. Next state RD2.
  - RD2: `ram_rdata` is valid.
    - CPU owner: `avs_readdata=ram_rdata`, `avs_waitrequest=0`.
    - JTAG owner: `MonDReg<=ram_rdata`, `jaddr<=jaddr+1`, clear `jpend`.
    - Next state IDLE.
- **Address wrap.** `jaddr` wraps from 2^ADDR_W-1 to 0 (modulo ADDR_W bits).
- **`jtag_busy`.** Equals `jpend` OR (state≠IDLE AND owner=JTAG).
- **CPU rule.** Avalon requires the CPU to hold its request until `avs_waitrequest=0`. The CPU is never granted twice back-to-back while `jpend` is set.

## Timing
- **Reset values.**
  - State IDLE, `jpend=0`, `jaddr=0`, `last`=CPU.
  - `MonDReg=0`, `jtag_overrun=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `ram_be=0`.
  - `avs_waitrequest=1` (it is low only in the completion cycle), `avs_readdata=0` outside RD2, `jtag_busy=0`.
- **Latency from the request being seen in IDLE at edge N.**
  - Write: completes in cycle N+1 (2 cycles).
  - Read: completes in cycle N+2 (3 cycles).
  - JTAG strobe at N: earliest grant is the IDLE cycle N+1.
- **Back-to-back.** After completion the FSM is in IDLE on the next cycle, so a new grant is possible immediately.
- **Reset mid-operation.** Asserting `reset_n=0` forces IDLE and `ram_we=0` immediately (asynchronously). The pending command is lost and the CPU sees `avs_waitrequest=1`.
- **Simultaneous strobes.** With `take_action_ocimem_a` and a command strobe in the same cycle:
  - The address load applies first.
  - The command is accepted with the new address.

## Test plan
1. **JTAG write, read back, auto-increment.**
   - Stimulus: `jdo=5` with `take_action_ocimem_a`; `jdo[31:0]=32'hDEADBEEF` with `take_action_ocimem_b`; reload address 5; `take_no_action_ocimem_a`.
   - Required: RAM[5]=DEADBEEF; `MonDReg=DEADBEEF` 3 cycles after the read is granted; `jaddr=6`.
2. **CPU write and read.**
   - Stimulus: `avs_write` addr 3 with data 32'h12345678 and `be=4'b0011`; then `avs_read` addr 3.
   - Required: write takes 2 cycles; `ram_be=0011`; read returns `avs_waitrequest` low in cycle 3 with the RAM value.
3. **Fairness.** Stimulus: continuous CPU reads while a JTAG read is issued. Required: the JTAG read is granted at the next IDLE after the current CPU operation; the CPU is not granted twice in a row while `jpend=1`.
4. **Overrun.**
   - Stimulus: two `take_no_action_ocimem_a` strobes 1 cycle apart.
   - Required: the second is dropped and `jtag_overrun=1`; it is cleared by the next `take_action_ocimem_a`.
5. **Wrap.** Stimulus: with `ADDR_W=8`, `jaddr=8'hFF`, issue a JTAG write. Required: `jaddr` becomes 0.
6. **Reset mid-read.**
   - Stimulus: assert `reset_n=0` in RD1.
   - Required: `ram_we=0`, `jtag_busy=0` and `MonDReg=0` immediately; the FSM is in IDLE after release.

Source files
------------

// File: rtl/nios2_debug_ocimem_arbiter_if.sv
// Avalon debug-slave and OCI RAM port bundle shared by the arbiter and its
// environment. The slave modport is the arbiter's view.
interface nios2_debug_ocimem_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [BE_W-1:0]   avs_byteenable;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BE_W-1:0]   ram_be;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // CPU master plus RAM model side
    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest,
        input  ram_addr, ram_wdata, ram_be, ram_we,
        output ram_rdata
    );

    // Arbiter side
    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest,
        output ram_addr, ram_wdata, ram_be, ram_we,
        input  ram_rdata
    );
endinterface

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the OCI debug RAM between the JTAG command path and the CPU Avalon
// slave, with a one-entry JTAG command buffer and alternating tie-break.
module nios2_debug_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic        jtag_busy,
    output logic        jtag_overrun,
    nios2_debug_ocimem_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD1,
        ST_RD2
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_JTAG
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              jpend_q, jpend_d;
    logic              jwr_q, jwr_d;
    logic [DATA_W-1:0] jdata_q, jdata_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [BE_W-1:0]   ram_be_q, ram_be_d;
    logic              ram_we_q, ram_we_d;
    logic              waitreq_q, waitreq_d;

    logic              creq;
    logic              grant_j;
    logic              grant_c;
    logic              jtag_active;
    logic              cmd_strobe;
    logic [ADDR_W-1:0] jaddr_inc;
    logic              unused_jdo;

    assign unused_jdo = ^jdo[37:32];

    assign creq        = bus.avs_read | bus.avs_write;
    assign jtag_active = (state_q != ST_IDLE) && (owner_q == OWN_JTAG);
    assign cmd_strobe  = take_action_ocimem_b | take_no_action_ocimem_a;
    assign jaddr_inc   = jaddr_q + ADDR_W'(1);

    // On a tie, whichever side was not served last wins
    assign grant_j = (state_q == ST_IDLE) && jpend_q && (!creq || (last_q == OWN_CPU));
    assign grant_c = (state_q == ST_IDLE) && creq && !grant_j;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        jpend_d     = jpend_q;
        jwr_d       = jwr_q;
        jdata_d     = jdata_q;
        jaddr_d     = jaddr_q;
        mon_d       = mon_q;
        overrun_d   = overrun_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        ram_we_d    = 1'b0;
        waitreq_d   = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_j) begin
                    owner_d     = OWN_JTAG;
                    last_d      = OWN_JTAG;
                    ram_addr_d  = jaddr_q;
                    ram_wdata_d = jdata_q;
                    ram_be_d    = {BE_W{1'b1}};
                    if (jwr_q) begin
                        ram_we_d = 1'b1;
                        state_d  = ST_WR;
                    end else begin
                        state_d  = ST_RD1;
                    end
                end else if (grant_c) begin
                    owner_d     = OWN_CPU;
                    last_d      = OWN_CPU;
                    ram_addr_d  = bus.avs_address;
                    ram_wdata_d = bus.avs_writedata;
                    ram_be_d    = bus.avs_byteenable;
                    if (bus.avs_write) begin
                        ram_we_d  = 1'b1;
                        waitreq_d = 1'b0;
                        state_d   = ST_WR;
                    end else begin
                        state_d   = ST_RD1;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_JTAG) begin
                    jaddr_d = jaddr_inc;
                    jpend_d = 1'b0;
                end
            end
            ST_RD1: begin
                state_d = ST_RD2;
                if (owner_q == OWN_CPU) begin
                    waitreq_d = 1'b0;
                end
            end
            ST_RD2: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_JTAG) begin
                    mon_d   = bus.ram_rdata;
                    jaddr_d = jaddr_inc;
                    jpend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Address load overrides any auto-increment from a completing JTAG op
        if (take_action_ocimem_a) begin
            jaddr_d   = jdo[ADDR_W-1:0];
            overrun_d = 1'b0;
        end

        if (cmd_strobe) begin
            if (jpend_q || jtag_active) begin
                overrun_d = 1'b1;
            end else begin
                jpend_d = 1'b1;
                jwr_d   = take_action_ocimem_b;
                if (take_action_ocimem_b) begin
                    jdata_d = jdo[DATA_W-1:0];
                end
            end
        end

        busy_d = jpend_d | ((state_d != ST_IDLE) && (owner_d == OWN_JTAG));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_CPU;
            jpend_q     <= 1'b0;
            jwr_q       <= 1'b0;
            jdata_q     <= '0;
            jaddr_q     <= '0;
            mon_q       <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            ram_we_q    <= 1'b0;
            waitreq_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            jpend_q     <= jpend_d;
            jwr_q       <= jwr_d;
            jdata_q     <= jdata_d;
            jaddr_q     <= jaddr_d;
            mon_q       <= mon_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            ram_we_q    <= ram_we_d;
            waitreq_q   <= waitreq_d;
        end
    end

    // RAM data is only valid in RD2, so the CPU read path bypasses the flops
    assign bus.avs_readdata = ((state_q == ST_RD2) && (owner_q == OWN_CPU)) ? bus.ram_rdata : '0;

    assign bus.avs_waitrequest = waitreq_q;
    assign bus.ram_addr        = ram_addr_q;
    assign bus.ram_wdata       = ram_wdata_q;
    assign bus.ram_be          = ram_be_q;
    assign bus.ram_we          = ram_we_q;
    assign MonDReg             = mon_q;
    assign jtag_busy           = busy_q;
    assign jtag_overrun        = overrun_q;
endmodule
